// File: rtl/lbp_update_gen.sv
// lbp_update_gen: builds bht_update words for the local branch predictor.
// Records frontend predictions in an in-order queue and pairs each one with
// the resolution from execute, producing a one-cycle update and mispredict flag.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_bp_i               synchronous queue flush; blocks same-cycle push/resolve
//   debug_mode_i             blocks pushes, forces update valid and mispredict to 0
//   push_valid_i/ready_o     frontend record handshake (ready is combinational)
//   push_pc_i/taken_i/index_i  predicted branch PC, direction, metadata index
//   resolve_valid_i/pc_i/taken_i  resolution of the oldest branch
//   bht_update_o             registered {valid, pc, taken, index}
//   mispredict_o, orphan_o   registered one-cycle pulses
//   occupancy_o              current record count
module lbp_update_gen #(
  parameter int unsigned VLEN     = 32,
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_bp_i,
  input  logic                         debug_mode_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [VLEN-1:0]              push_pc_i,
  input  logic                         push_taken_i,
  input  logic [IDX_BITS-1:0]          push_index_i,
  input  logic                         resolve_valid_i,
  input  logic [VLEN-1:0]              resolve_pc_i,
  input  logic                         resolve_taken_i,
  output logic [VLEN+IDX_BITS+1:0]     bht_update_o,
  output logic                         mispredict_o,
  output logic                         orphan_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned UW = VLEN + IDX_BITS + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [VLEN-1:0]     pc;
    logic                taken;
    logic [IDX_BITS-1:0] idx;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          head_rec;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [UW-1:0] upd_q, upd_d;
  logic          mis_q, mis_d;
  logic          orph_q, orph_d;
  logic          push_acc;

  assign head_rec     = mem_q[head_q];
  assign push_ready_o = (count_q < DEPTH_C) && !debug_mode_i && !flush_bp_i;
  assign push_acc     = push_valid_i && push_ready_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    upd_d   = '0;
    mis_d   = 1'b0;
    orph_d  = 1'b0;
    if (flush_bp_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (resolve_valid_i) begin
        if (count_q == '0) begin
          orph_d = 1'b1;
        end else if (head_rec.pc == resolve_pc_i) begin
          head_d  = head_q + PW'(1);
          count_d = count_q - CW'(1);
          upd_d   = {!debug_mode_i, head_rec.pc, resolve_taken_i, head_rec.idx};
          mis_d   = (head_rec.taken ^ resolve_taken_i) & !debug_mode_i;
        end else begin
          // Resync: drop everything; a same-cycle push lands at tail_q,
          // which becomes the new head.
          orph_d  = 1'b1;
          head_d  = tail_q;
          count_d = '0;
        end
      end
      if (push_acc) begin
        tail_d  = tail_q + PW'(1);
        count_d = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      upd_q   <= '0;
      mis_q   <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      upd_q   <= upd_d;
      mis_q   <= mis_d;
      orph_q  <= orph_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_q[tail_q] <= {push_pc_i, push_taken_i, push_index_i};
    end
  end

  assign bht_update_o = upd_q;
  assign mispredict_o = mis_q;
  assign orphan_o     = orph_q;
  assign occupancy_o  = count_q;

endmodule

// File: tb/tb_lbp_update_gen.sv
module tb_lbp_update_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_bp_i;
  logic        debug_mode_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_pc_i;
  logic        push_taken_i;
  logic [7:0]  push_index_i;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic        resolve_taken_i;
  logic [41:0] bht_update_o;
  logic        mispredict_o;
  logic        orphan_o;
  logic [3:0]  occupancy_o;

  int nvec = 0;
  int nerr = 0;

  lbp_update_gen #(.VLEN(32), .IDX_BITS(8), .DEPTH(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_bp_i     (flush_bp_i),
    .debug_mode_i   (debug_mode_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_pc_i      (push_pc_i),
    .push_taken_i   (push_taken_i),
    .push_index_i   (push_index_i),
    .resolve_valid_i(resolve_valid_i),
    .resolve_pc_i   (resolve_pc_i),
    .resolve_taken_i(resolve_taken_i),
    .bht_update_o   (bht_update_o),
    .mispredict_o   (mispredict_o),
    .orphan_o       (orphan_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] upd(input logic v, input logic [31:0] pc,
                                      input logic t, input logic [7:0] idx);
    return {v, pc, t, idx};
  endfunction

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                     input logic [7:0] pidx, input logic rv, input logic [31:0] rpc,
                     input logic rt);
    push_valid_i    = pv;
    push_pc_i       = ppc;
    push_taken_i    = pt;
    push_index_i    = pidx;
    resolve_valid_i = rv;
    resolve_pc_i    = rpc;
    resolve_taken_i = rt;
    @(posedge clk_i);
    #1;
    push_valid_i    = 1'b0;
    resolve_valid_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [7:0] idx);
    cyc(1'b1, pc, t, idx, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t);
    cyc(1'b0, 32'h0, 1'b0, 8'h0, 1'b1, pc, t);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_ni          = 1'b0;
    flush_bp_i      = 1'b0;
    debug_mode_i    = 1'b0;
    push_valid_i    = 1'b0;
    push_pc_i       = '0;
    push_taken_i    = 1'b0;
    push_index_i    = '0;
    resolve_valid_i = 1'b0;
    resolve_pc_i    = '0;
    resolve_taken_i = 1'b0;

    // Reset state
    #3;
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_ready", 64'(push_ready_o), 64'd1);
    chk("rst_upd", 64'(bht_update_o), 64'd0);
    chk("rst_mis", 64'(mispredict_o), 64'd0);
    chk("rst_orph", 64'(orphan_o), 64'd0);
    #5 rst_ni = 1'b1;

    // Basic match
    push(32'h1000, 1'b0, 8'h3A);
    chk("basic_occ1", 64'(occupancy_o), 64'd1);
    resolve(32'h1000, 1'b1);
    chk("basic_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h1000, 1'b1, 8'h3A)));
    chk("basic_mis", 64'(mispredict_o), 64'd1);
    chk("basic_orph", 64'(orphan_o), 64'd0);
    chk("basic_occ0", 64'(occupancy_o), 64'd0);
    idle();
    chk("basic_upd_clr", 64'(bht_update_o), 64'd0);
    chk("basic_mis_clr", 64'(mispredict_o), 64'd0);

    // Fill to DEPTH
    for (int k = 0; k < 8; k++) begin
      push(32'h100 + 32'(4 * k), (k % 2) == 1, 8'h10 + 8'(k));
    end
    chk("full_occ", 64'(occupancy_o), 64'd8);
    chk("full_ready", 64'(push_ready_o), 64'd0);
    // 9th push rejected even with a same-cycle matched pop
    cyc(1'b1, 32'h999, 1'b1, 8'hEE, 1'b1, 32'h100, 1'b0);
    chk("full_pop_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h100, 1'b0, 8'h10)));
    chk("full_pop_mis", 64'(mispredict_o), 64'd0);
    chk("full_pop_occ", 64'(occupancy_o), 64'd7);
    for (int k = 1; k < 8; k++) begin
      resolve(32'h100 + 32'(4 * k), 1'b1);
      chk("drain_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h100 + 32'(4 * k), 1'b1, 8'h10 + 8'(k))));
      chk("drain_mis", 64'(mispredict_o), ((k % 2) == 1) ? 64'd0 : 64'd1);
    end
    chk("drain_occ", 64'(occupancy_o), 64'd0);

    // Across the wrap, with simultaneous push and pop
    push(32'h400, 1'b1, 8'h50);
    cyc(1'b1, 32'h404, 1'b1, 8'h51, 1'b1, 32'h400, 1'b1);
    chk("wrap0_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h400, 1'b1, 8'h50)));
    chk("wrap0_occ", 64'(occupancy_o), 64'd1);
    cyc(1'b1, 32'h408, 1'b1, 8'h52, 1'b1, 32'h404, 1'b1);
    chk("wrap1_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h404, 1'b1, 8'h51)));
    chk("wrap1_occ", 64'(occupancy_o), 64'd1);
    resolve(32'h408, 1'b0);
    chk("wrap2_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h408, 1'b0, 8'h52)));
    chk("wrap2_mis", 64'(mispredict_o), 64'd1);
    chk("wrap2_occ", 64'(occupancy_o), 64'd0);

    // Mismatch resync
    push(32'h200, 1'b0, 8'h20);
    push(32'h204, 1'b0, 8'h21);
    resolve(32'h204, 1'b0);
    chk("mm_orph", 64'(orphan_o), 64'd1);
    chk("mm_upd", 64'(bht_update_o), 64'd0);
    chk("mm_occ", 64'(occupancy_o), 64'd0);
    idle();
    chk("mm_orph_clr", 64'(orphan_o), 64'd0);
    // Mismatch with a same-cycle push keeps only the new record
    push(32'h220, 1'b0, 8'h22);
    cyc(1'b1, 32'h224, 1'b1, 8'h24, 1'b1, 32'h228, 1'b0);
    chk("mmp_orph", 64'(orphan_o), 64'd1);
    chk("mmp_occ", 64'(occupancy_o), 64'd1);
    resolve(32'h224, 1'b1);
    chk("mmp_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h224, 1'b1, 8'h24)));
    chk("mmp_orph0", 64'(orphan_o), 64'd0);

    // Empty-queue orphan with same-cycle push
    cyc(1'b1, 32'h300, 1'b0, 8'h33, 1'b1, 32'h300, 1'b0);
    chk("eo_orph", 64'(orphan_o), 64'd1);
    chk("eo_upd", 64'(bht_update_o), 64'd0);
    chk("eo_occ", 64'(occupancy_o), 64'd1);
    resolve(32'h300, 1'b0);
    chk("eo_upd2", 64'(bht_update_o), 64'(upd(1'b1, 32'h300, 1'b0, 8'h33)));
    chk("eo_mis2", 64'(mispredict_o), 64'd0);
    chk("eo_orph2", 64'(orphan_o), 64'd0);

    // Flush
    for (int k = 0; k < 5; k++) begin
      push(32'h500 + 32'(4 * k), 1'b1, 8'h60 + 8'(k));
    end
    chk("fl_occ5", 64'(occupancy_o), 64'd5);
    flush_bp_i = 1'b1;
    #1;
    chk("fl_ready", 64'(push_ready_o), 64'd0);
    cyc(1'b1, 32'h600, 1'b0, 8'h66, 1'b1, 32'h500, 1'b0);
    flush_bp_i = 1'b0;
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_upd", 64'(bht_update_o), 64'd0);
    chk("fl_mis", 64'(mispredict_o), 64'd0);
    chk("fl_orph", 64'(orphan_o), 64'd0);
    resolve(32'h500, 1'b1);
    chk("fl_after_orph", 64'(orphan_o), 64'd1);

    // Debug mode
    push(32'h700, 1'b0, 8'h77);
    debug_mode_i = 1'b1;
    #1;
    chk("dbg_ready", 64'(push_ready_o), 64'd0);
    cyc(1'b1, 32'h710, 1'b0, 8'h71, 1'b1, 32'h700, 1'b1);
    chk("dbg_upd", 64'(bht_update_o), 64'(upd(1'b0, 32'h700, 1'b1, 8'h77)));
    chk("dbg_mis", 64'(mispredict_o), 64'd0);
    chk("dbg_occ", 64'(occupancy_o), 64'd0);
    resolve(32'h700, 1'b1);
    chk("dbg_orph", 64'(orphan_o), 64'd1);
    debug_mode_i = 1'b0;

    // Async reset mid-stream
    for (int k = 0; k < 5; k++) begin
      push(32'h800 + 32'(4 * k), 1'b0, 8'h80 + 8'(k));
    end
    resolve(32'h800, 1'b1);
    chk("ar_pre_upd", 64'(bht_update_o), 64'(upd(1'b1, 32'h800, 1'b1, 8'h80)));
    chk("ar_pre_occ", 64'(occupancy_o), 64'd4);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_upd", 64'(bht_update_o), 64'd0);
    chk("ar_mis", 64'(mispredict_o), 64'd0);
    chk("ar_occ", 64'(occupancy_o), 64'd0);
    chk("ar_ready", 64'(push_ready_o), 64'd1);
    rst_ni = 1'b1;
    resolve(32'h804, 1'b0);
    chk("ar_orph", 64'(orphan_o), 64'd1);
    chk("ar_upd2", 64'(bht_update_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
